// File: rtl/sender_ot_pkg.sv
// Shared types and helpers for the OT sender packer and its modexp unit.
package sender_ot_pkg;

  typedef enum logic [2:0] {IDLE, CHK, EXP, RED, NEXT, DONE} state_t;

  typedef enum logic {OP_EXP, OP_RED} mx_op_t;

  // Worst-case cycles from gen acceptance to gen_end.
  function automatic int latency_bound(input int num_msg, input int width);
    return num_msg * (2 * width + 3) * (width + 2) + 4;
  endfunction

  // Bit offset of channel ch inside a flat NUM_MSG*WIDTH bus.
  function automatic int chan_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/sender_ot_pack_multi_if.sv
// Job request / result bundle between the key store, the packer and the link transmitter.
interface sender_ot_pack_multi_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_MSG = 2
);
  logic                     gen;
  logic                     abort;
  logic [NUM_MSG*WIDTH-1:0] message;
  logic [NUM_MSG*WIDTH-1:0] rand_val;
  logic [WIDTH-1:0]         N;
  logic [WIDTH-1:0]         d;
  logic [WIDTH-1:0]         received_data;
  logic [NUM_MSG*WIDTH-1:0] packed_data;
  logic                     gen_end;
  logic                     busy;
  logic                     err;

  modport master (
    output gen, abort, message, rand_val, N, d, received_data,
    input  packed_data, gen_end, busy, err
  );

  modport slave (
    input  gen, abort, message, rand_val, N, d, received_data,
    output packed_data, gen_end, busy, err
  );
endinterface

// File: rtl/ot_modexp_unit.sv
// Sequential modexp (right-to-left binary) and shift-subtract reduction sharing one
// double-and-add-mod-N step; every multiply or reduction takes exactly WIDTH+1 steps.
module ot_modexp_unit
  import sender_ot_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  mx_op_t           op,
  input  logic [WIDTH:0]   operand,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             done
);
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] STEPS = CNT_W'(WIDTH + 1);

  typedef enum logic [2:0] {U_IDLE, U_BRED, U_CHKE, U_MUL1, U_MUL2, U_RRED, U_DONE} ustate_t;

  ustate_t          ustate_reg, ustate_next;
  logic [WIDTH-1:0] acc_reg, a_reg, mod_reg, exp_reg, base_reg, res_reg;
  logic [WIDTH:0]   mulr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH:0]   dbl, mod_ext, add_val, t2;
  logic [WIDTH-1:0] t1, acc_next;
  logic             last_step;

  // acc < N always holds, so 2*acc and t1+addend stay below 2N: one subtract each.
  always_comb begin
    mod_ext = {1'b0, mod_reg};
    dbl     = {acc_reg, 1'b0};
    t1      = (dbl >= mod_ext) ? dbl[WIDTH-1:0] - mod_reg : dbl[WIDTH-1:0];
    if (ustate_reg == U_BRED || ustate_reg == U_RRED)
      add_val = {{WIDTH{1'b0}}, mulr_reg[WIDTH]};
    else
      add_val = mulr_reg[WIDTH] ? {1'b0, a_reg} : '0;
    t2       = {1'b0, t1} + add_val;
    acc_next = (t2 >= mod_ext) ? t2[WIDTH-1:0] - mod_reg : t2[WIDTH-1:0];
  end

  assign last_step = (cnt_reg == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ustate_reg <= U_IDLE;
    else     ustate_reg <= ustate_next;
  end

  always_comb begin
    ustate_next = ustate_reg;
    case (ustate_reg)
      U_IDLE:  if (start) ustate_next = (op == OP_EXP) ? U_BRED : U_RRED;
      U_BRED:  if (last_step) ustate_next = U_CHKE;
      U_CHKE:  ustate_next = (exp_reg == '0) ? U_DONE : U_MUL1;
      U_MUL1:  if (last_step) ustate_next = U_MUL2;
      U_MUL2:  if (last_step) ustate_next = U_CHKE;
      U_RRED:  if (last_step) ustate_next = U_DONE;
      default: ustate_next = U_IDLE;
    endcase
    if (clear) ustate_next = U_IDLE;
  end

  assign done   = (ustate_reg == U_DONE);
  assign result = res_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg  <= '0;
      a_reg    <= '0;
      mod_reg  <= '0;
      exp_reg  <= '0;
      base_reg <= '0;
      res_reg  <= '0;
      mulr_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      case (ustate_reg)
        U_IDLE: if (start) begin
          mod_reg  <= modulus;
          exp_reg  <= exponent;
          res_reg  <= (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
          mulr_reg <= operand;
          acc_reg  <= '0;
          cnt_reg  <= STEPS;
        end
        U_CHKE: if (exp_reg != '0) begin
          mulr_reg <= {1'b0, res_reg};
          a_reg    <= base_reg;
          acc_reg  <= '0;
          cnt_reg  <= STEPS;
        end
        U_BRED, U_MUL1, U_MUL2, U_RRED: begin
          acc_reg  <= acc_next;
          mulr_reg <= {mulr_reg[WIDTH-1:0], 1'b0};
          cnt_reg  <= cnt_reg - CNT_W'(1);
          if (last_step) begin
            acc_reg <= '0;
            cnt_reg <= STEPS;
            case (ustate_reg)
              U_BRED: base_reg <= acc_next;
              // Multiply always runs so timing is independent of the exponent bit value.
              U_MUL1: begin
                if (exp_reg[0]) res_reg <= acc_next;
                mulr_reg <= {1'b0, base_reg};
                a_reg    <= base_reg;
              end
              U_MUL2: begin
                base_reg <= acc_next;
                exp_reg  <= exp_reg >> 1;
              end
              default: res_reg <= acc_next;
            endcase
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/sender_ot_pack_multi.sv
// OT sender packer: packed_i = (m_i + (v - x_i)^d mod N) mod N for NUM_MSG channels,
// processed in ascending order through one time-shared modexp unit.
module sender_ot_pack_multi
  import sender_ot_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_MSG = 2
) (
  input logic                   clk,
  input logic                   rst,
  sender_ot_pack_multi_if.slave bus
);
  localparam int CW = $clog2(NUM_MSG);

  state_t                   state_reg, state_next;
  logic [CW-1:0]            ch_reg;
  logic [WIDTH-1:0]         msg_reg    [NUM_MSG];
  logic [WIDTH-1:0]         rnd_reg    [NUM_MSG];
  logic [WIDTH-1:0]         shadow_reg [NUM_MSG];
  logic [WIDTH-1:0]         packed_reg [NUM_MSG];
  logic [WIDTH-1:0]         msg_in     [NUM_MSG];
  logic [WIDTH-1:0]         rnd_in     [NUM_MSG];
  logic [WIDTH-1:0]         n_reg, d_reg, v_reg, r_reg;
  logic                     launched_reg, busy_reg, gen_end_reg, err_reg;
  logic                     cancel, v_ge;
  logic [WIDTH-1:0]         cur_m, cur_x, diff, addend;
  logic [WIDTH:0]           c_val;
  logic                     mx_start, mx_done;
  mx_op_t                   mx_op;
  logic [WIDTH:0]           mx_operand;
  logic [WIDTH-1:0]         mx_result;
  logic [NUM_MSG*WIDTH-1:0] packed_flat;

  for (genvar gi = 0; gi < NUM_MSG; gi++) begin : g_ch
    assign msg_in[gi] = bus.message[chan_lsb(gi, WIDTH) +: WIDTH];
    assign rnd_in[gi] = bus.rand_val[chan_lsb(gi, WIDTH) +: WIDTH];
    assign packed_flat[chan_lsb(gi, WIDTH) +: WIDTH] = packed_reg[gi];
  end

  assign cancel           = bus.abort && (state_reg != IDLE);
  assign bus.packed_data  = packed_flat;
  assign bus.gen_end      = gen_end_reg;
  assign bus.busy         = busy_reg;
  assign bus.err          = err_reg;

  // For v < x and odd d, (v-x)^d = -(|v-x|^d), i.e. N - r; N itself reduces to 0 later.
  always_comb begin
    cur_m  = msg_reg[ch_reg];
    cur_x  = rnd_reg[ch_reg];
    v_ge   = (v_reg >= cur_x);
    diff   = v_ge ? v_reg - cur_x : cur_x - v_reg;
    addend = (v_ge || !d_reg[0]) ? r_reg : n_reg - r_reg;
    c_val  = {1'b0, cur_m} + {1'b0, addend};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.gen) state_next = CHK;
      CHK:     state_next = (n_reg == '0) ? DONE : EXP;
      EXP:     if (mx_done) state_next = RED;
      RED:     if (mx_done) state_next = NEXT;
      NEXT:    state_next = (ch_reg == CW'(NUM_MSG - 1)) ? DONE : EXP;
      default: state_next = IDLE;
    endcase
    if (cancel) state_next = IDLE;
  end

  always_comb begin
    mx_start   = 1'b0;
    mx_op      = OP_EXP;
    mx_operand = {1'b0, diff};
    case (state_reg)
      EXP: mx_start = !launched_reg;
      RED: begin
        mx_start   = !launched_reg;
        mx_op      = OP_RED;
        mx_operand = c_val;
      end
      default: ;
    endcase
  end

  ot_modexp_unit #(.WIDTH(WIDTH)) u_modexp (
    .clk      (clk),
    .rst      (rst),
    .clear    (cancel),
    .start    (mx_start),
    .op       (mx_op),
    .operand  (mx_operand),
    .exponent (d_reg),
    .modulus  (n_reg),
    .result   (mx_result),
    .done     (mx_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_reg       <= '0;
      n_reg        <= '0;
      d_reg        <= '0;
      v_reg        <= '0;
      r_reg        <= '0;
      launched_reg <= 1'b0;
      busy_reg     <= 1'b0;
      gen_end_reg  <= 1'b0;
      err_reg      <= 1'b0;
      for (int i = 0; i < NUM_MSG; i++) begin
        msg_reg[i]    <= '0;
        rnd_reg[i]    <= '0;
        shadow_reg[i] <= '0;
        packed_reg[i] <= '0;
      end
    end else begin
      gen_end_reg <= 1'b0;
      if (cancel) begin
        busy_reg     <= 1'b0;
        launched_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: if (bus.gen) begin
            for (int i = 0; i < NUM_MSG; i++) begin
              msg_reg[i] <= msg_in[i];
              rnd_reg[i] <= rnd_in[i];
            end
            n_reg    <= bus.N;
            d_reg    <= bus.d;
            v_reg    <= bus.received_data;
            err_reg  <= 1'b0;
            busy_reg <= 1'b1;
          end
          CHK: begin
            ch_reg <= '0;
            if (n_reg == '0) err_reg <= 1'b1;
          end
          EXP, RED: begin
            if (mx_start) launched_reg <= 1'b1;
            if (mx_done) begin
              launched_reg <= 1'b0;
              if (state_reg == EXP) r_reg <= mx_result;
              else                  shadow_reg[ch_reg] <= mx_result;
            end
          end
          NEXT: if (ch_reg != CW'(NUM_MSG - 1)) ch_reg <= ch_reg + CW'(1);
          DONE: begin
            if (!err_reg) packed_reg <= shadow_reg;
            gen_end_reg <= 1'b1;
            busy_reg    <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sender_ot_pack_multi.sv
// Scoreboard bench for sender_ot_pack_multi: jobs push expected results, a monitor checks each gen_end.
module tb_sender_ot_pack_multi;
  import sender_ot_pkg::*;

  localparam int W     = 32;
  localparam int M     = 2;
  localparam int BOUND = latency_bound(M, W) + 16;

  typedef struct packed {
    logic [M*W-1:0] pk;
    logic           err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sender_ot_pack_multi_if #(.WIDTH(W), .NUM_MSG(M)) bus ();

  sender_ot_pack_multi #(.WIDTH(W), .NUM_MSG(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
  endtask

  // Monitor: every gen_end must match the oldest pending expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.gen_end === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_gen_end: got gen_end=1 with no job pending, required 0");
        end else begin
          e = sb_q.pop_front();
          $display("job done: packed_data=0x%016h err=%0b (expected 0x%016h err=%0b)",
                   bus.packed_data, bus.err, e.pk, e.err);
          check("packed_data", bus.packed_data, e.pk);
          check("err", 64'(bus.err), 64'(e.err));
          check("busy_at_gen_end", 64'(bus.busy), 64'd0);
          @(negedge clk);
          check("gen_end_one_cycle", 64'(bus.gen_end), 64'd0);
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] m0, m1, x0, x1, v, n, dd, input logic with_abort);
    @(posedge clk); #1;
    bus.message       = {m1, m0};
    bus.rand_val      = {x1, x0};
    bus.received_data = v;
    bus.N             = n;
    bus.d             = dd;
    bus.gen           = 1'b1;
    bus.abort         = with_abort;
    @(posedge clk); #1;
    bus.gen   = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (sb_q.size() != 0 && k < BOUND) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      $display("FAIL %s_timeout: no gen_end within %0d cycles, required completion", name, BOUND);
      sb_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic job(input string name, input logic [W-1:0] m0, m1, x0, x1, v, n, dd,
                     input logic [W-1:0] e0, e1, input logic eerr, input logic with_abort);
    exp_t e;
    e.pk  = {e1, e0};
    e.err = eerr;
    sb_q.push_back(e);
    issue(m0, m1, x0, x1, v, n, dd, with_abort);
    check({name, "_busy_after_accept"}, 64'(bus.busy), 64'd1);
    check({name, "_err_cleared"}, 64'(bus.err), 64'd0);
    wait_done(name);
  endtask

  initial begin : stim
    bus.gen = 1'b0; bus.abort = 1'b0;
    bus.message = '0; bus.rand_val = '0;
    bus.received_data = '0; bus.N = '0; bus.d = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_packed", bus.packed_data, 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_gen_end", 64'(bus.gen_end), 64'd0);
    check("reset_err", 64'(bus.err), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    //   name          m0  m1  x0 x1 v   N   d    exp0 exp1 err abort
    job("basic",       20, 7,  5, 9, 17, 33, 7,   32,  9,   0,  0);
    job("neg_odd",     20, 7,  5, 9, 3,  33, 7,   24,  10,  0,  0);
    job("v_eq_x",      40, 7,  5, 9, 5,  33, 7,   7,   24,  0,  0);
    job("d_zero",      20, 7,  5, 9, 17, 33, 0,   21,  8,   0,  0);
    job("n_zero",      20, 7,  5, 9, 17, 0,  7,   21,  8,   1,  0);
    check("err_sticky", 64'(bus.err), 64'd1);
    job("after_err",   20, 7,  5, 9, 17, 33, 7,   32,  9,   0,  0);
    job("n_one",       20, 7,  5, 9, 17, 1,  7,   0,   0,   0,  0);

    // A second gen while busy must be ignored.
    begin : ignored_gen
      exp_t e;
      e.pk = {32'd10, 32'd24}; e.err = 1'b0;
      sb_q.push_back(e);
      issue(20, 7, 5, 9, 3, 33, 7, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      bus.received_data = 17; bus.N = 0; bus.gen = 1'b1;
      @(posedge clk); #1 bus.gen = 1'b0;
      wait_done("ignored_gen");
      repeat (50) @(negedge clk);
    end

    job("gen_beats_abort", 20, 7, 5, 9, 17, 33, 7, 32, 9, 0, 1);

    // Abort while the first exponentiation is running.
    issue(20, 7, 5, 9, 3, 33, 7, 1'b0);
    repeat (10) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    repeat (800) @(negedge clk);
    check("abort_packed_kept", bus.packed_data, {32'd9, 32'd32});
    check("abort_still_idle", 64'(bus.busy), 64'd0);

    // Asynchronous reset in the middle of a reduction.
    issue(20, 7, 5, 9, 3, 33, 7, 1'b0);
    begin : wait_red
      int k = 0;
      while (dut.state_reg != RED && k < BOUND) begin
        @(negedge clk);
        k++;
      end
      if (dut.state_reg != RED) begin
        checks++;
        $display("FAIL reach_red: state never reached RED within %0d cycles", BOUND);
      end
    end
    #2 rst = 1'b1;
    #1;
    check("async_rst_packed", bus.packed_data, 64'd0);
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_err", 64'(bus.err), 64'd0);
    check("async_rst_gen_end", 64'(bus.gen_end), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    job("after_reset", 20, 7, 5, 9, 17, 33, 7, 32, 9, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sender_ot_pack_multi.md
Name: sender_ot_pack_multi

Overview:
- Parametrised oblivious-transfer sender packer. Computes NUM_MSG packed words packed_i = (m_i + (v - x_i)^d mod N) mod N, where v is the receiver's blinded value and x_i the per-channel random values.
- Generalises the 2-channel 32-bit sender packer:
  - width and channel count are parameters;
  - adds busy/err status, an abort input and defined corner-case results.
- Sits between the sender's key/message store and the link transmitter.

Parameters:
- WIDTH, 32, operand width of messages, N, d, random values and v.
- NUM_MSG, 2, number of message channels (2..16).
- CW, $clog2(NUM_MSG), channel index width (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- gen  in  1  start request; accepted only when busy=0.
- abort  in  1  synchronous cancel of a running job.
- message  in  NUM_MSG*WIDTH  messages; channel i at bits [i*WIDTH +: WIDTH].
- rand_val  in  NUM_MSG*WIDTH  random values x_i, same packing.
- N  in  WIDTH  RSA modulus.
- d  in  WIDTH  private exponent.
- received_data  in  WIDTH  v from the receiver.
- packed_data  out  NUM_MSG*WIDTH  results, same packing.
- gen_end  out  1  one-cycle done pulse.
- busy  out  1  job in progress.
- err  out  1  N==0 detected on the last job; sticky until the next accepted gen.

Behaviour:
- Reset (async, any state): state=IDLE; packed_data=0, gen_end=0, busy=0, err=0; internal operand registers cleared; sub-module reset.
- Accept: gen=1 in IDLE latches all inputs in that cycle, clears err, sets busy=1 next cycle. Inputs may change afterwards. gen while busy=1 is ignored with no side effects.
- FSM states and transitions:
  - IDLE: on gen go to CHK.
  - CHK: if N==0, set err=1 and go to DONE; packed_data is left unchanged. Otherwise ch=0 and go to EXP.
  - EXP: diff = |v - x_ch|; start modexp(diff, d, N); wait for the exponent-done indication, capture r, go to RED.
  - RED:
    - c = m_ch + r if v >= x_ch;
    - c = m_ch + r if v < x_ch and d is even;
    - c = m_ch + (N - r) if v < x_ch and d is odd;
    - c is held in WIDTH+1 bits. Start modexp-unit reduction c mod N; result goes to shadow slot ch.
  - NEXT: if ch == NUM_MSG-1 go to DONE, else ch+1 and go to EXP.
  - DONE: copy shadow to packed_data, pulse gen_end for one cycle, busy=0, return to IDLE.
- Channels are processed strictly in ascending order. packed_data updates atomically in DONE only, and is stable from gen_end until the next DONE.
- Corner cases:
  - v == x_i gives diff=0, so r=0 for d>0.
  - d=0 gives r = 1 mod N, including when diff=0.
  - N=1 gives every result 0.
  - m_i >= N is allowed; the final reduction handles it.
- abort=1 while busy: go to IDLE next cycle, busy=0, no gen_end, packed_data unchanged, sub-module returns to idle. abort has no effect in IDLE. If abort and gen arrive in the same IDLE cycle, gen wins.
- Latency: data-dependent, at most NUM_MSG*(2*WIDTH+3)*(WIDTH+2)+4 cycles. It does not depend on channel values beyond the bit-lengths of d and c.

Decomposition:
- Package sender_ot_pkg: FSM state enum (IDLE, CHK, EXP, RED, NEXT, DONE), the latency-bound function and a channel-slice helper function.
- One sub-module, ot_modexp_unit (WIDTH parameter, same clk/rst):
  - right-to-left binary modular exponentiation;
  - a shift-subtract modular reduction mode (op select), accepting a WIDTH+1-bit dividend;
  - start/done pulse handshake.
- The top level instantiates exactly one ot_modexp_unit and time-shares it.

Test Plan:
- NUM_MSG=2, N=33, d=7, x0=5, x1=9, v=17, m0=20, m1=7 -> packed_data={9,32} (slot1=9, slot0=32), one gen_end pulse, busy low afterwards, err=0.
- Same keys, v=3 (negative diffs, odd d) -> slot0=24, slot1=10.
- v=5=x0, m0=40 -> slot0=7 (0 + 40 mod 33); d=0 with v=17 -> slot0=(20+1) mod 33=21.
- N=0 -> err=1, gen_end pulses, packed_data retains its previous value; the next valid gen clears err.
- gen pulsed again mid-job with different inputs -> ignored; results match the first job. abort mid-EXP -> no gen_end, outputs unchanged.
- rst asserted mid-RED between clock edges -> all outputs 0 immediately; a fresh job afterwards produces correct results.
